// File: rtl/riscv_ctrl_fsm_if.sv
// Control-FSM bundle: instruction/branch/memory-ready inputs and every datapath select and strobe.
// master = control FSM side, slave = datapath/memory side.
interface riscv_ctrl_fsm_if;
  logic [31:0] inst;
  logic        br_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic [2:0]  imm_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  alu_op;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state_o;

  modport master (
    input  inst, br_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
           alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, illegal, state_o
  );

  modport slave (
    output inst, br_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
           alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, illegal, state_o
  );
endinterface

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing with
// request timeout and a sticky trap state.
module riscv_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input logic              clk,
  input logic              rst_n,
  riscv_ctrl_fsm_if.master bus
);
  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;
  localparam logic [TO_W-1:0] LimitM1 = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch = 3'd0, StDecode = 3'd1, StExec = 3'd2, StMem = 3'd3, StWb = 3'd4, StTrap = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsAluR, ClsAluI, ClsLoad, ClsStore, ClsBranch, ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBad
  } cls_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            hold_q;  // first cycle after reset: every strobe suppressed
  cls_e            cls;
  logic [2:0]      imm_dec;
  logic            waiting;
  logic            timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == LimitM1);

  always_comb begin
    cls     = ClsBad;
    imm_dec = I_TYPE;
    case (bus.inst[6:0])
      7'b0110011: cls = ClsAluR;
      7'b0010011: cls = ClsAluI;
      7'b0000011: cls = ClsLoad;
      7'b1100111: cls = ClsJalr;
      7'b0100011: begin cls = ClsStore;  imm_dec = S_TYPE; end
      7'b1100011: begin cls = ClsBranch; imm_dec = B_TYPE; end
      7'b0110111: begin cls = ClsLui;    imm_dec = U_TYPE; end
      7'b0010111: begin cls = ClsAuipc;  imm_dec = U_TYPE; end
      7'b1101111: begin cls = ClsJal;    imm_dec = J_TYPE; end
      default:    cls = ClsBad;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    waiting       = 1'b0;
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.ir_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.imm_sel   = I_TYPE;
    bus.alu_a_sel = 1'b0;
    bus.alu_b_sel = 1'b0;
    bus.alu_op    = 2'b00;
    bus.rf_we     = 1'b0;
    bus.wb_sel    = 2'b00;
    unique case (state_q)
      StFetch: begin
        if (!hold_q) begin
          bus.imem_req = 1'b1;
          if (bus.imem_ready) begin
            bus.ir_we = 1'b1;
            state_d   = StDecode;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      StDecode: begin
        bus.imm_sel = imm_dec;
        state_d     = (cls == ClsBad) ? StTrap : StExec;
      end
      StExec: begin
        bus.imm_sel = imm_dec;
        state_d     = StWb;
        case (cls)
          ClsAluR:  bus.alu_op = 2'b01;
          ClsAluI:  begin bus.alu_b_sel = 1'b1; bus.alu_op = 2'b10; end
          ClsLui:   begin bus.alu_b_sel = 1'b1; bus.alu_op = 2'b11; end
          ClsAuipc: begin bus.alu_a_sel = 1'b1; bus.alu_b_sel = 1'b1; end
          ClsLoad, ClsStore: begin
            bus.alu_b_sel = 1'b1;
            state_d       = StMem;
          end
          ClsBranch: begin
            bus.alu_a_sel = 1'b1;
            bus.alu_b_sel = 1'b1;
            bus.pc_we     = 1'b1;
            bus.pc_sel    = bus.br_taken;
            state_d       = StFetch;
          end
          ClsJal, ClsJalr: begin
            bus.alu_a_sel = (cls == ClsJal);
            bus.alu_b_sel = 1'b1;
            bus.pc_we     = 1'b1;
            bus.pc_sel    = 1'b1;
            bus.rf_we     = 1'b1;
            bus.wb_sel    = 2'b10;
            state_d       = StFetch;
          end
          default: state_d = StTrap;
        endcase
      end
      StMem: begin
        bus.imm_sel   = imm_dec;
        bus.alu_b_sel = 1'b1;
        bus.dmem_req  = 1'b1;
        bus.dmem_we   = (cls == ClsStore);
        if (bus.dmem_ready) begin
          if (cls == ClsStore) begin
            bus.pc_we = 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StWb;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      StWb: begin
        bus.imm_sel = imm_dec;
        bus.rf_we   = 1'b1;
        bus.wb_sel  = (cls == ClsLoad) ? 2'b01 : 2'b00;
        bus.pc_we   = 1'b1;
        state_d     = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
    // A ready on the limit cycle takes the normal path because waiting is then 0.
    if (waiting && timeout_hit) state_d = StTrap;
    if (state_d == StTrap) illegal_d = 1'b1;
    if (bus.inst[11:7] == 5'd0) bus.rf_we = 1'b0;
    cnt_d       = waiting ? cnt_q + 1'b1 : '0;
    bus.illegal = illegal_q;
    bus.state_o = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      hold_q    <= 1'b0;
    end
  end
endmodule
